// File: rtl/mlp_axis_pkg.sv
// rtl/mlp_axis_pkg.sv - shared types and constants for the MLP AXIS packet transmitter
package mlp_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEST_MVM0 = 1;
    localparam int DEST_MVM1 = 2;
    localparam int DEST_OUT  = 3;

    localparam int LENW_DEF = 8;

endpackage

// File: rtl/mlp_sync_fifo.sv
// rtl/mlp_sync_fifo.sv - payload FIFO with combinational head; a new word becomes poppable one cycle after its push
module mlp_sync_fifo #(
    parameter int DATAW  = 32,
    parameter int FIFOD  = 64,
    parameter int FIFOAW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic [DATAW-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [DATAW-1:0]  mem [FIFOD];
    logic [FIFOAW-1:0] wr_ptr;
    logic [FIFOAW-1:0] rd_ptr;
    logic [FIFOAW:0]   count;
    logic              fresh;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (FIFOAW+1)'(FIFOD));
    // The word written on the previous edge is not yet visible to the reader.
    assign empty   = (count == {{FIFOAW{1'b0}}, fresh});
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fresh  <= 1'b0;
        end else begin
            fresh <= do_push;
            if (do_push) wr_ptr <= wr_ptr + FIFOAW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFOAW'(1);
            if (do_push && !do_pop)
                count <= count + (FIFOAW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (FIFOAW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mlp_axis_packet_tx.sv
// rtl/mlp_axis_packet_tx.sv - TDEST-tagged AXIS packet source for the MLP crossbar; MLP_PKT_TX_STATS_EN adds traffic counters
module mlp_axis_packet_tx
    import mlp_axis_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int IDW    = 32,
    parameter int USERW  = 32,
    parameter int DESTW  = 6,
    parameter int LENW   = LENW_DEF,
    parameter int FIFOD  = 64,
    parameter int FIFOAW = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DESTW-1:0] cmd_dest,
    input  logic [IDW-1:0]   cmd_id,
    input  logic [USERW-1:0] cmd_user,
    input  logic [LENW-1:0]  cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DATAW-1:0] wr_data,
    output logic             axis_m_tvalid,
    input  logic             axis_m_tready,
    output logic [DATAW-1:0] axis_m_tdata,
    output logic             axis_m_tlast,
    output logic [IDW-1:0]   axis_m_tid,
    output logic [USERW-1:0] axis_m_tuser,
    output logic [DESTW-1:0] axis_m_tdest
`ifdef MLP_PKT_TX_STATS_EN
    ,
    output logic [31:0]      stat_pkts,
    output logic [31:0]      stat_beats,
    output logic [31:0]      stat_stalls
`endif
);

    state_t           state;
    logic [LENW:0]    remaining;
    logic [DESTW-1:0] pkt_dest;
    logic [IDW-1:0]   pkt_id;
    logic [USERW-1:0] pkt_user;
    logic [DATAW-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic             hs;

    mlp_sync_fifo #(
        .DATAW (DATAW),
        .FIFOD (FIFOD),
        .FIFOAW(FIFOAW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_valid),
        .push_data(wr_data),
        .pop      (load),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = !fifo_full;
    assign hs        = axis_m_tvalid && axis_m_tready;
    assign load      = (state == SEND) && (remaining != '0) && !fifo_empty
                       && (!axis_m_tvalid || axis_m_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            pkt_dest      <= '0;
            pkt_id        <= '0;
            pkt_user      <= '0;
            axis_m_tvalid <= 1'b0;
            axis_m_tlast  <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tid    <= '0;
            axis_m_tuser  <= '0;
            axis_m_tdest  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    pkt_dest  <= cmd_dest;
                    pkt_id    <= cmd_id;
                    pkt_user  <= cmd_user;
                    remaining <= {1'b0, cmd_len} + (LENW+1)'(1);
                    state     <= SEND;
                end
                SEND:    if (load && remaining == (LENW+1)'(1)) state <= DRAIN;
                DRAIN:   if (hs && axis_m_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
            // Output register refills in the same cycle as a handshake to keep 1 beat/cycle.
            if (load) begin
                axis_m_tvalid <= 1'b1;
                axis_m_tdata  <= fifo_head;
                axis_m_tlast  <= (remaining == (LENW+1)'(1));
                axis_m_tid    <= pkt_id;
                axis_m_tuser  <= pkt_user;
                axis_m_tdest  <= pkt_dest;
                remaining     <= remaining - (LENW+1)'(1);
            end else if (hs) begin
                axis_m_tvalid <= 1'b0;
                axis_m_tlast  <= 1'b0;
            end
        end
    end

`ifdef MLP_PKT_TX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts   <= '0;
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (hs)                 stat_beats  <= stat_beats + 32'd1;
            if (hs && axis_m_tlast) stat_pkts   <= stat_pkts + 32'd1;
            if (axis_m_tvalid && !axis_m_tready)
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_axis_packet_tx.sv
// tb/tb_mlp_axis_packet_tx.sv - randomized self-checking bench for mlp_axis_packet_tx
module tb_mlp_axis_packet_tx;
    import mlp_axis_pkg::*;

    localparam int DATAW = 32;
    localparam int IDW   = 32;
    localparam int USERW = 32;
    localparam int DESTW = 6;
    localparam int LENW  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [DESTW-1:0] cmd_dest = '0;
    logic [IDW-1:0]   cmd_id = '0;
    logic [USERW-1:0] cmd_user = '0;
    logic [LENW-1:0]  cmd_len = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [DATAW-1:0] wr_data = '0;
    logic             axis_m_tvalid;
    logic             axis_m_tready;
    logic [DATAW-1:0] axis_m_tdata;
    logic             axis_m_tlast;
    logic [IDW-1:0]   axis_m_tid;
    logic [USERW-1:0] axis_m_tuser;
    logic [DESTW-1:0] axis_m_tdest;
`ifdef MLP_PKT_TX_STATS_EN
    logic [31:0]      stat_pkts;
    logic [31:0]      stat_beats;
    logic [31:0]      stat_stalls;
`endif

    mlp_axis_packet_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dest     (cmd_dest),
        .cmd_id       (cmd_id),
        .cmd_user     (cmd_user),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .axis_m_tvalid(axis_m_tvalid),
        .axis_m_tready(axis_m_tready),
        .axis_m_tdata (axis_m_tdata),
        .axis_m_tlast (axis_m_tlast),
        .axis_m_tid   (axis_m_tid),
        .axis_m_tuser (axis_m_tuser),
        .axis_m_tdest (axis_m_tdest)
`ifdef MLP_PKT_TX_STATS_EN
        ,
        .stat_pkts    (stat_pkts),
        .stat_beats   (stat_beats),
        .stat_stalls  (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: payload words in push order and the packet in flight.
    logic [DATAW-1:0] wq[$];
    logic [DATAW-1:0] exp_data;
    bit               active = 1'b0;
    int               beat_idx = 0;
    logic [LENW-1:0]  cur_len = '0;
    logic [DESTW-1:0] cur_dest = '0;
    logic [IDW-1:0]   cur_id = '0;
    logic [USERW-1:0] cur_user = '0;
    int               beats_m = 0, pkts_m = 0, stalls_m = 0;
    int               cyc = 0, first_hs = 0, last_hs = 0;
    bit               prev_valid = 1'b0, prev_hs = 1'b0, prev_stall = 1'b0;
    logic [DATAW-1:0] held_data = '0;
    logic             held_last = 1'b0;
    int               tready_mode = 3;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            wq.delete();
            active = 1'b0;
            prev_valid = 1'b0;
            prev_hs = 1'b0;
            prev_stall = 1'b0;
            beats_m = 0;
            pkts_m = 0;
            stalls_m = 0;
        end else begin
            if (prev_stall) begin
                check("stall_tdata", axis_m_tdata, held_data);
                check("stall_tlast", axis_m_tlast, held_last);
            end
            if (prev_valid && !prev_hs) check("tvalid_held", axis_m_tvalid, 1);
            if (axis_m_tvalid && axis_m_tready) begin
                check("beat_in_packet", active, 1);
                check("model_has_word", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    exp_data = wq.pop_front();
                    check("tdata", axis_m_tdata, exp_data);
                end
                check("tlast", axis_m_tlast, beat_idx == int'(cur_len));
                check("tid", axis_m_tid, cur_id);
                check("tuser", axis_m_tuser, cur_user);
                check("tdest", axis_m_tdest, cur_dest);
                if (beat_idx == 0) first_hs = cyc;
                last_hs = cyc;
                beats_m++;
                if (beat_idx == int'(cur_len)) begin
                    active = 1'b0;
                    pkts_m++;
                end else begin
                    beat_idx++;
                end
            end
            if (axis_m_tvalid && !axis_m_tready) stalls_m++;
            if (wr_valid && wr_ready) wq.push_back(wr_data);
            if (cmd_valid && cmd_ready) begin
                check("cmd_when_idle", active, 0);
                cur_len  = cmd_len;
                cur_dest = cmd_dest;
                cur_id   = cmd_id;
                cur_user = cmd_user;
                active   = 1'b1;
                beat_idx = 0;
            end
            prev_valid = axis_m_tvalid;
            prev_hs    = axis_m_tvalid && axis_m_tready;
            prev_stall = axis_m_tvalid && !axis_m_tready;
            held_data  = axis_m_tdata;
            held_last  = axis_m_tlast;
        end
    end

    initial begin
        bit pat[4];
        int pat_i;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat_i = 0;
        axis_m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       axis_m_tready = 1'b1;
                1:       axis_m_tready = pat[pat_i % 4];
                2:       axis_m_tready = 1'($urandom_range(0, 1));
                default: axis_m_tready = 1'b0;
            endcase
            pat_i++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DATAW-1:0] w);
        bit ok;
        int n;
        wr_data  = w;
        wr_valid = 1'b1;
        n = 0;
        do begin
            ok = wr_ready;
            step(1);
            n++;
        end while (!ok && n < 2000);
        wr_valid = 1'b0;
        if (!ok) check("push_accept", ok, 1);
    endtask

    task automatic send_cmd(input int dest, input logic [IDW-1:0] id,
                            input logic [USERW-1:0] user, input int len);
        bit ok;
        int n;
        cmd_dest  = DESTW'(dest);
        cmd_id    = id;
        cmd_user  = user;
        cmd_len   = LENW'(len);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            ok = cmd_ready;
            step(1);
            n++;
        end while (!ok && n < 2000);
        cmd_valid = 1'b0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (active && n < 5000) begin
            step(1);
            n++;
        end
        check("pkt_done", active, 0);
    endtask

    initial begin
        int b0, len, pre;
        rst_n = 1'b0;
        step(3);
        check("rst_tvalid", axis_m_tvalid, 0);
        check("rst_tlast", axis_m_tlast, 0);
        check("rst_tdata", axis_m_tdata, 0);
        check("rst_tid", axis_m_tid, 0);
        check("rst_tuser", axis_m_tuser, 0);
        check("rst_tdest", axis_m_tdest, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_ready", wr_ready, 1);
        rst_n = 1'b1;
        step(2);

        // Preloaded 4-beat packet at full rate.
        tready_mode = 0;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        send_cmd(DEST_MVM0, 32'd7, 32'hA5, 3);
        check("t1_lat_accept_edge", axis_m_tvalid, 0);
        step(1);
        for (int k = 0; k < 4; k++) begin
            check("t1_burst_valid", axis_m_tvalid, 1);
            check("t1_busy", cmd_ready, 0);
            step(1);
        end
        check("t1_cmd_ready_back", cmd_ready, 1);
        check("t1_tvalid_off", axis_m_tvalid, 0);
        check("t1_span", last_hs - first_hs, 3);

        // Same shape with TREADY toggling 1,0,0,1.
        tready_mode = 1;
        for (int k = 0; k < 4; k++) push_word($urandom);
        send_cmd(DEST_MVM1, $urandom, $urandom, 3);
        wait_idle();
`ifdef MLP_PKT_TX_STATS_EN
        check("t2_stat_stalls", stat_stalls, stalls_m);
`endif

        // Fill the FIFO completely, then drain it as one 64-beat packet.
        tready_mode = 3;
        for (int i = 0; i < 64; i++) begin
            push_word($urandom);
            check("t3_wr_ready", wr_ready, i < 63);
        end
        wr_data  = 32'hDEAD;
        wr_valid = 1'b1;
        step(3);
        check("t3_held_off", wr_ready, 0);
        wr_valid = 1'b0;
        tready_mode = 0;
        send_cmd(DEST_OUT, $urandom, $urandom, 63);
        wait_idle();
        check("t3_span", last_hs - first_hs, 63);
        check("t3_wr_ready_after", wr_ready, 1);

        // Single-beat packet, then write-to-valid latency into an empty FIFO.
        push_word(32'hDEAD);
        send_cmd(DEST_MVM0, $urandom, $urandom, 0);
        wait_idle();
        step(1);
        check("t4_idle", cmd_ready, 1);
        send_cmd(DEST_MVM1, $urandom, $urandom, 0);
        step(2);
        push_word(32'hBEEF);
        check("t4_lat_t0", axis_m_tvalid, 0);
        step(1);
        check("t4_lat_t1", axis_m_tvalid, 0);
        step(1);
        check("t4_lat_t2", axis_m_tvalid, 1);
        wait_idle();

        // Slow producer: one word every 3 cycles gives bubbles.
        b0 = beats_m;
        send_cmd(DEST_OUT, $urandom, $urandom, 7);
        for (int i = 0; i < 8; i++) begin
            push_word($urandom);
            step(2);
        end
        wait_idle();
        check("t5_beats", beats_m - b0, 8);
        check("t5_span", last_hs - first_hs, 21);

        // Reset in the middle of an 8-beat packet.
        for (int i = 0; i < 3; i++) push_word($urandom);
        b0 = beats_m;
        send_cmd(DEST_MVM0, $urandom, $urandom, 7);
        for (int n = 0; n < 100 && (beats_m - b0) < 2; n++) step(1);
        check("t6_pre_valid", axis_m_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", axis_m_tvalid, 0);
        check("t6_rst_tdata", axis_m_tdata, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        check("t6_rst_wr_ready", wr_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(1);
        tready_mode = 2;
        push_word($urandom); push_word($urandom);
        send_cmd(DEST_MVM1, $urandom, $urandom, 1);
        wait_idle();
        check("t6_pkts_after_rst", pkts_m, 1);

        // Random packets with words split around the command and random backpressure.
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(0, 9);
            pre = $urandom_range(0, len + 1);
            for (int i = 0; i < pre; i++) push_word($urandom);
            send_cmd($urandom_range(1, 3), $urandom, $urandom, len);
            for (int i = 0; i < len + 1 - pre + int'($urandom_range(0, 1)); i++)
                push_word($urandom);
            wait_idle();
        end

`ifdef MLP_PKT_TX_STATS_EN
        check("stat_pkts", stat_pkts, pkts_m);
        check("stat_beats", stat_beats, beats_m);
        check("stat_stalls", stat_stalls, stalls_m);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
